// File: rtl/narrow_word_packer_pkg.sv
// -----------------------------------------------------------------------------
// narrow_word_packer_pkg
//   Shared defaults for the narrow/wide FIFO pair and a constant function used
//   to size the piece counters.
//
//   DEF_NARROW : width of one piece popped from the upstream FIFO
//   DEF_RATIO  : pieces per assembled word
//   clog2()    : ceil(log2(value)), usable in parameter context
// -----------------------------------------------------------------------------
package narrow_word_packer_pkg;

  localparam int unsigned DEF_NARROW = 4;
  localparam int unsigned DEF_RATIO  = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/narrow_word_packer_if.sv
// -----------------------------------------------------------------------------
// narrow_word_packer_if
//   valid/ready word stream leaving the packer.
//
//   out_valid : out_data holds a complete word         (master -> slave)
//   out_ready : slave takes the word at valid && ready (slave  -> master)
//   out_data  : assembled word, piece 0 in the LSBs    (master -> slave)
// -----------------------------------------------------------------------------
interface narrow_word_packer_if
  import narrow_word_packer_pkg::*;
#(
  parameter int unsigned WIDE = DEF_NARROW * DEF_RATIO
) ();

  logic            out_valid;
  logic            out_ready;
  logic [WIDE-1:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);

endinterface

// File: rtl/narrow_word_packer_out_buf.sv
// -----------------------------------------------------------------------------
// packer_out_buf
//   Two-entry WIDE-bit FIFO presenting its head on a valid/ready stream.
//   A write and a read on the same edge are both honoured. The writer must
//   never write while the buffer holds two words.
//
//   clk, rst    : clock, asynchronous active-high reset
//   i_wr_en     : write i_wr_data at this edge
//   i_wr_data   : word to store
//   i_rd_ready  : consumer takes the head at this edge if o_valid
//   o_valid     : at least one word stored
//   o_data      : head word (stable until it is read)
//   o_count     : number of stored words, 0..2
// -----------------------------------------------------------------------------
module packer_out_buf
  import narrow_word_packer_pkg::*;
#(
  parameter int unsigned WIDE = DEF_NARROW * DEF_RATIO
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [WIDE-1:0] i_wr_data,
  input  logic            i_rd_ready,
  output logic            o_valid,
  output logic [WIDE-1:0] o_data,
  output logic [1:0]      o_count
);

  logic [WIDE-1:0] r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;

  logic            w_rd_fire;

  assign o_valid   = (r_count != 2'd0);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_rd_fire = o_valid && i_rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is reset as well, so out_data reads 0 after reset
      // instead of whatever a previous run left behind.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_wr_en, w_rd_fire})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/narrow_word_packer.sv
// -----------------------------------------------------------------------------
// narrow_word_packer
//   Pops NARROW-bit pieces from an upstream FIFO and reassembles them
//   LSB-first into WIDE-bit words (WIDE = NARROW*RATIO), presented through a
//   two-entry valid/ready buffer. A pop is only issued when the piece it
//   returns is guaranteed a place, so nothing is lost under backpressure.
//
//   clk, rst      : clock, asynchronous active-high reset
//   i_fifo_empty  : upstream FIFO has no piece
//   o_fifo_pop    : pop request; the piece arrives on i_fifo_q one cycle later
//   i_fifo_q      : piece returned for the pop sampled at the previous edge
//   out_if        : word stream (out_valid / out_ready / out_data)
//   o_busy        : a partial word, an in-flight pop or a buffered word exists
// -----------------------------------------------------------------------------
module narrow_word_packer
  import narrow_word_packer_pkg::*;
#(
  parameter int unsigned NARROW = DEF_NARROW,
  parameter int unsigned RATIO  = DEF_RATIO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_pop,
  input  logic [NARROW-1:0]    i_fifo_q,
  narrow_word_packer_if.master out_if,
  output logic                 o_busy
);

  localparam int unsigned      WIDE  = NARROW * RATIO;
  localparam int unsigned      CNT_W = clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]             r_issue_cnt;  // pops issued, modulo RATIO
  logic [CNT_W-1:0]             r_cap_cnt;    // pieces captured, modulo RATIO
  logic                         r_pend;       // a popped piece arrives this cycle
  logic [RATIO-1:0][NARROW-1:0] r_acc;

  logic [RATIO-1:0][NARROW-1:0] w_word;
  logic                         w_final_in_flight;
  logic [1:0]                   w_count;
  logic [1:0]                   w_reserved;

  // The arriving piece completes a word exactly when it lands in the last
  // slot; that same condition is the buffer write.
  assign w_final_in_flight = r_pend && (r_cap_cnt == LAST);

  // Buffer slots already spoken for: stored words plus a completing word whose
  // last piece is still on its way. Only the pop of a final piece needs a free
  // slot; earlier pieces always fit in the accumulator.
  assign w_reserved = w_count + {1'b0, w_final_in_flight};
  assign o_fifo_pop = !rst && !i_fifo_empty &&
                      ((r_issue_cnt != LAST) || (w_reserved < 2'd2));

  // The final piece bypasses the accumulator and goes straight into the buffer.
  always_comb begin
    // NOTE: every output gets a full default before the override, so no
    // path leaves a bit unassigned and no latch is inferred.
    w_word          = r_acc;
    w_word[RATIO-1] = i_fifo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_pend      <= 1'b0;
      r_acc       <= '0;
    end else begin
      // NOTE: non-blocking updates, so every register here reads the values
      // from before this edge regardless of statement order.
      r_pend <= o_fifo_pop;
      if (o_fifo_pop) begin
        r_issue_cnt <= (r_issue_cnt == LAST) ? '0 : r_issue_cnt + CNT_W'(1);
      end
      if (r_pend) begin
        r_acc[r_cap_cnt] <= i_fifo_q;
        r_cap_cnt        <= (r_cap_cnt == LAST) ? '0 : r_cap_cnt + CNT_W'(1);
      end
    end
  end

  packer_out_buf #(.WIDE(WIDE)) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_final_in_flight),
    .i_wr_data  (w_word),
    .i_rd_ready (out_if.out_ready),
    .o_valid    (out_if.out_valid),
    .o_data     (out_if.out_data),
    .o_count    (w_count)
  );

  assign o_busy = (r_cap_cnt != '0) || (r_issue_cnt != r_cap_cnt) ||
                  r_pend || (w_count != 2'd0);

endmodule

// File: tb/tb_narrow_word_packer.sv
// -----------------------------------------------------------------------------
// tb_narrow_word_packer
//   Two packers (RATIO=2 and RATIO=4, NARROW=4) fed by behavioural upstream
//   FIFOs. The RATIO=2 instance is checked every cycle against a count-based
//   model: pops issued, pieces captured and words accepted determine what
//   fifo_pop, out_valid, busy and out_data must be. Directed scenarios add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_narrow_word_packer;

  localparam int R2 = 2;

  logic clk;
  logic rst;
  logic rst_req;
  int   n_tests;
  int   n_fail;

  // RATIO=2 instance
  logic       empty2;
  logic       pop2;
  logic       busy2;
  logic [3:0] q2;
  narrow_word_packer_if #(.WIDE(8)) if2 ();
  narrow_word_packer #(.NARROW(4), .RATIO(2)) dut2 (
    .clk(clk), .rst(rst), .i_fifo_empty(empty2), .o_fifo_pop(pop2),
    .i_fifo_q(q2), .out_if(if2), .o_busy(busy2)
  );

  // RATIO=4 instance
  logic       empty4;
  logic       pop4;
  logic       busy4;
  logic [3:0] q4;
  narrow_word_packer_if #(.WIDE(16)) if4 ();
  narrow_word_packer #(.NARROW(4), .RATIO(4)) dut4 (
    .clk(clk), .rst(rst), .i_fifo_empty(empty4), .o_fifo_pop(pop4),
    .i_fifo_q(q4), .out_if(if4), .o_busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream contents and model state
  logic [3:0] up2[$];
  logic [3:0] up4[$];
  logic [3:0] part2[$];
  logic [7:0] exp2[$];
  logic [7:0] got2[$];
  int         pops2, caps2, acc2, pops4;
  logic       pend_m, pop_s, fire_s, hold_prev, pop4_s;
  logic [7:0] held_data;
  int         ready_mode;  // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit later and
  // stay valid through the next rising edge.
  always @(negedge clk) begin
    logic pop_exp, valid_exp, busy_exp;
    rst = rst_req;
    if (rst) begin
      up2.delete(); up4.delete(); part2.delete(); exp2.delete();
      pops2 = 0; caps2 = 0; acc2 = 0; pops4 = 0;
      pend_m = 1'b0; pop_s = 1'b0; fire_s = 1'b0; hold_prev = 1'b0; pop4_s = 1'b0;
      q2 = '0; q4 = '0;
    end else begin
      // Account for the rising edge that just happened.
      if (pend_m) caps2++;
      pend_m = pop_s;
      if (pop_s && up2.size() != 0) begin
        pops2++;
        q2 = up2.pop_front();
        part2.push_back(q2);
        if (part2.size() == R2) begin
          exp2.push_back({part2[1], part2[0]});
          part2.delete();
        end
      end
      if (fire_s) begin
        acc2++;
        if (exp2.size() != 0) void'(exp2.pop_front());
      end
      if (pop4_s && up4.size() != 0) begin
        pops4++;
        q4 = up4.pop_front();
      end
    end
    case (ready_mode)
      0:       if2.out_ready = 1'b0;
      1:       if2.out_ready = 1'b1;
      default: if2.out_ready = 1'($urandom_range(0, 1));
    endcase
    if4.out_ready = 1'b0;
    empty2 = (up2.size() == 0);
    empty4 = (up4.size() == 0);
    #1;
    // A pop only needs a free buffer slot when it fetches a word's last piece.
    pop_exp   = !rst && !empty2 &&
                (((pops2 % R2) != R2 - 1) || ((pops2 / R2 - acc2) < 2));
    valid_exp = !rst && ((caps2 / R2) > acc2);
    busy_exp  = !rst && (pops2 != acc2 * R2);
    check("fifo_pop", pop2, pop_exp);
    check("out_valid", if2.out_valid, valid_exp);
    check("busy", busy2, busy_exp);
    if (if2.out_valid === 1'b1) begin
      if (exp2.size() == 0) check("out_valid_no_word", if2.out_valid, 0);
      else check("out_data", if2.out_data, exp2[0]);
    end
    if (hold_prev) begin
      check("hold_valid", if2.out_valid, 1);
      check("hold_data", if2.out_data, held_data);
    end
    hold_prev = !rst && if2.out_valid && !if2.out_ready;
    held_data = if2.out_data;
    pop_s     = pop2;
    fire_s    = if2.out_valid && if2.out_ready;
    if (fire_s) got2.push_back(if2.out_data);
    pop4_s    = pop4;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_byte2(input logic [7:0] b);
    up2.push_back(b[3:0]);
    up2.push_back(b[7:4]);
  endtask

  task automatic wait_acc(input int target, input int budget, input string name, output int took);
    took = 0;
    while (acc2 < target && took < budget) begin
      tick();
      took++;
    end
    check(name, 32'(acc2 >= target), 1);
  endtask

  initial begin
    int         took;
    int         base;
    int         pbase;
    logic [7:0] w;
    n_tests = 0; n_fail = 0;
    rst_req = 1'b1; rst = 1'b1; ready_mode = 1;
    empty2 = 1'b1; empty4 = 1'b1; q2 = '0; q4 = '0;
    if2.out_ready = 1'b0; if4.out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", if2.out_valid, 0);
    check("rst_data", if2.out_data, 0);
    check("rst_busy", busy2, 0);
    check("rst_pop", pop2, 0);
    check("rst_valid4", if4.out_valid, 0);
    rst_req = 1'b0;
    tick();

    // Upstream empty throughout: nothing happens
    repeat (20) tick();
    check("idle_pops", pops2, 0);
    check("idle_valid", if2.out_valid, 0);
    check("idle_busy", busy2, 0);

    // Bytes 1..64 with out_ready high: one word every 2 clocks
    got2.delete();
    for (int i = 1; i <= 64; i++) push_byte2(8'(i));
    wait_acc(64, 400, "t1_done", took);
    // Word k is accepted at edge 2k+2, so word 64 is counted 131 ticks in.
    check("t1_throughput", 32'(took <= 131), 1);
    repeat (4) tick();
    check("t1_busy_end", busy2, 0);
    check("t1_count", got2.size(), 64);
    for (int i = 0; i < got2.size(); i++) check("t1_word", got2[i], 32'(i + 1));

    // Backpressure: two words buffered plus the first piece of a third in the
    // accumulator, so exactly 5 pops, then fifo_pop stays low.
    got2.delete();
    ready_mode = 0;
    base  = acc2;
    pbase = pops2;
    for (int i = 1; i <= 64; i++) push_byte2(8'(i));
    repeat (30) tick();
    check("t2_pops", pops2 - pbase, 5);
    check("t2_pop_stopped", pop2, 0);
    check("t2_valid", if2.out_valid, 1);
    check("t2_head", if2.out_data, 8'h01);
    check("t2_busy", busy2, 1);
    ready_mode = 1;
    wait_acc(base + 64, 400, "t2_done", took);
    repeat (4) tick();
    check("t2_count", got2.size(), 64);
    for (int i = 0; i < got2.size(); i++) check("t2_word", got2[i], 32'(i + 1));
    check("t2_busy_end", busy2, 0);

    // Reset with one piece captured: partial word is discarded
    up2.push_back(4'h5);
    repeat (4) tick();
    check("t5_partial_busy", busy2, 1);
    check("t5_partial_valid", if2.out_valid, 0);
    rst_req = 1'b1;
    tick();
    check("t5_rst_valid", if2.out_valid, 0);
    check("t5_rst_busy", busy2, 0);
    rst_req = 1'b0;
    tick();
    tick();
    got2.delete();
    up2.push_back(4'hA);
    up2.push_back(4'hB);
    wait_acc(1, 20, "t5_done", took);
    w = (got2.size() != 0) ? got2[0] : 8'h00;
    check("t5_word", w, 8'hBA);

    // RATIO=4: pieces 1,2,3,4 -> 0x4321. Last pop at edge 4, visible after
    // edge 5, i.e. on the 6th sampling tick after loading.
    for (int i = 1; i <= 4; i++) up4.push_back(4'(i));
    took = 0;
    while (if4.out_valid !== 1'b1 && took < 20) begin
      tick();
      took++;
    end
    check("t4_latency", took, 6);
    check("t4_word", if4.out_data, 16'h4321);
    check("t4_pops", pops4, 4);
    check("t4_busy", busy4, 1);

    // Random backpressure over 1000 words
    got2.delete();
    base = acc2;
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) push_byte2(8'((i * 37 + 11) & 255));
    wait_acc(base + 1000, 10000, "t6_done", took);
    ready_mode = 1;
    repeat (4) tick();
    check("t6_count", got2.size(), 1000);
    for (int i = 0; i < got2.size(); i++) check("t6_word", got2[i], 32'((i * 37 + 11) & 255));
    check("t6_busy_end", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
